// File: rtl/inv_delay_monitor.sv
// Measures stim-to-resp propagation delay of an inverter in clk cycles,
// with polarity, timeout and retrigger detection plus min/max statistics.
module inv_delay_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned TIMEOUT     = 1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic             clr_stats,
  input  logic             stim,
  input  logic             resp,
  output logic [CNT_W-1:0] delay_cnt,
  output logic             delay_valid,
  output logic             timeout,
  output logic             retrig,
  output logic             polarity_err,
  output logic [CNT_W-1:0] min_delay,
  output logic [CNT_W-1:0] max_delay,
  output logic             busy
);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] MEASURE = 1'b1;

  localparam int unsigned        ARM_W    = $clog2(SYNC_STAGES + 2);
  localparam logic [ARM_W-1:0]   ARM_DONE = ARM_W'(SYNC_STAGES + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  logic [SYNC_STAGES-1:0] stim_sync;
  logic [SYNC_STAGES-1:0] resp_sync;
  logic                   stim_prev;
  logic                   resp_prev;
  logic [ARM_W-1:0]       arm_cnt;
  logic                   armed;
  logic                   stim_s;
  logic                   resp_s;
  logic                   stim_edge;
  logic                   resp_edge;

  logic [0:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic                   exp_lvl;

  logic [0:0]             state_d;
  logic [CNT_W-1:0]       cnt_d;
  logic                   exp_d;
  logic [CNT_W-1:0]       dly_d;
  logic                   dv_d;
  logic                   to_d;
  logic                   rt_d;
  logic                   perr_set;

  assign stim_s    = stim_sync[SYNC_STAGES-1];
  assign resp_s    = resp_sync[SYNC_STAGES-1];
  assign armed     = (arm_cnt == ARM_DONE);
  // prev registers always follow the synced value, so the level present at
  // reset release is absorbed during the arm window instead of firing an edge
  assign stim_edge = armed && (stim_s != stim_prev);
  assign resp_edge = armed && (resp_s != resp_prev);
  assign busy      = (state == MEASURE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stim_sync <= '0;
      resp_sync <= '0;
      stim_prev <= 1'b0;
      resp_prev <= 1'b0;
      arm_cnt   <= '0;
    end else begin
      stim_sync <= {stim_sync[SYNC_STAGES-2:0], stim};
      resp_sync <= {resp_sync[SYNC_STAGES-2:0], resp};
      stim_prev <= stim_s;
      resp_prev <= resp_s;
      if (!armed) arm_cnt <= arm_cnt + ARM_W'(1);
    end
  end

  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    exp_d    = exp_lvl;
    dly_d    = delay_cnt;
    dv_d     = 1'b0;
    to_d     = 1'b0;
    rt_d     = 1'b0;
    perr_set = 1'b0;
    case (state)
      IDLE: begin
        if (enable && stim_edge) begin
          if (resp_edge) begin
            dv_d     = 1'b1;
            dly_d    = '0;
            perr_set = (resp_s != ~stim_s);
          end else begin
            state_d = MEASURE;
            cnt_d   = '0;
            exp_d   = ~stim_s;
          end
        end
      end
      default: begin
        if (!enable) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt + CNT_W'(1);
          if (resp_edge) begin
            dv_d     = 1'b1;
            dly_d    = cnt + CNT_W'(1);
            perr_set = (resp_s != exp_lvl);
            // a coincident stim edge closes this measurement and opens the next
            if (stim_edge) begin
              cnt_d = '0;
              exp_d = ~stim_s;
            end else begin
              state_d = IDLE;
            end
          end else if (stim_edge) begin
            rt_d  = 1'b1;
            cnt_d = '0;
            exp_d = ~stim_s;
          end else if (cnt == CNT_LAST) begin
            to_d    = 1'b1;
            state_d = IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      exp_lvl     <= 1'b0;
      delay_cnt   <= '0;
      delay_valid <= 1'b0;
      timeout     <= 1'b0;
      retrig      <= 1'b0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      exp_lvl     <= exp_d;
      delay_cnt   <= dly_d;
      delay_valid <= dv_d;
      timeout     <= to_d;
      retrig      <= rt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      polarity_err <= 1'b0;
      min_delay    <= '1;
      max_delay    <= '0;
    end else if (clr_stats) begin
      polarity_err <= 1'b0;
      min_delay    <= '1;
      max_delay    <= '0;
    end else begin
      if (perr_set) polarity_err <= 1'b1;
      if (dv_d) begin
        if (dly_d < min_delay) min_delay <= dly_d;
        if (dly_d > max_delay) max_delay <= dly_d;
      end
    end
  end

endmodule

// File: tb/tb_inv_delay_monitor.sv
// Directed bench for inv_delay_monitor: vector table of single measurements
// followed by hand-written multi-cycle sequences.
module tb_inv_delay_monitor;

  localparam int ONES = 65535;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        clr_stats;
  logic        stim;
  logic        resp;
  logic [15:0] delay_cnt;
  logic        delay_valid;
  logic        timeout;
  logic        retrig;
  logic        polarity_err;
  logic [15:0] min_delay;
  logic [15:0] max_delay;
  logic        busy;

  int total  = 0;
  int passed = 0;

  inv_delay_monitor #(
    .SYNC_STAGES(2),
    .CNT_W      (16),
    .TIMEOUT    (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .clr_stats   (clr_stats),
    .stim        (stim),
    .resp        (resp),
    .delay_cnt   (delay_cnt),
    .delay_valid (delay_valid),
    .timeout     (timeout),
    .retrig      (retrig),
    .polarity_err(polarity_err),
    .min_delay   (min_delay),
    .max_delay   (max_delay),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit   chg;
    logic s;
    logic r;
    int   off;
    int   d;
    int   perr;
    int   mn;
    int   mx;
    bit   clr;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got 1, expected 0");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int hits;
    int first;
    int cnt1;
    int cnt2;
    int d0;
    int d1;
    string tag;

    // stim held high through reset: arm window must swallow it
    rst_n = 1'b0; enable = 1'b1; clr_stats = 1'b0; stim = 1'b1; resp = 1'b0;
    repeat (3) step();
    chk("rst_delay_cnt", int'(delay_cnt), 0);
    chk("rst_min", int'(min_delay), ONES);
    chk("rst_max", int'(max_delay), 0);
    chk("rst_outs", int'({delay_valid, timeout, retrig, polarity_err, busy}), 0);
    rst_n = 1'b1;
    hits = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (busy || delay_valid || retrig || timeout) hits++;
    end
    chk("arm_no_edge", hits, 0);

    rst_n = 1'b0; stim = 1'b0; resp = 1'b1;
    repeat (2) step();
    rst_n = 1'b1;
    repeat (6) step();

    vecs[0] = '{1'b1, 1'b1, 1'b0, 5, 5, 0, 5,    5, 1'b1};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 7, 7, 0, 7,    7, 1'b0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 3, 3, 0, 3,    7, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 9, 9, 0, 3,    9, 1'b0};
    vecs[4] = '{1'b1, 1'b1, 1'b0, 0, 0, 0, 0,    9, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b1, 0, 0, 0, ONES, 0, 1'b0};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 3, 3, 1, 3,    3, 1'b1};

    for (int i = 0; i < 7; i++) begin
      tag = $sformatf("v%0d", i);
      if (vecs[i].chg) begin
        step();
        stim = vecs[i].s;
        repeat (vecs[i].off) step();
        resp = vecs[i].r;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
          step();
          if (delay_valid) begin
            lat = k;
            break;
          end
        end
        chk({tag, "_latency"}, lat, 3);
        chk({tag, "_delay"}, int'(delay_cnt), vecs[i].d);
      end else begin
        step();
        resp = vecs[i].r;
        hits = 0;
        for (int k = 0; k < 8; k++) begin
          step();
          if (delay_valid || busy) hits++;
        end
        chk({tag, "_resp_alone_ignored"}, hits, 0);
      end
      chk({tag, "_perr"}, int'(polarity_err), vecs[i].perr);
      chk({tag, "_min"}, int'(min_delay), vecs[i].mn);
      chk({tag, "_max"}, int'(max_delay), vecs[i].mx);
      step(); step();
      if (vecs[i].clr) begin
        clr_stats = 1'b1;
        step();
        clr_stats = 1'b0;
        chk({tag, "_clr_perr"}, int'(polarity_err), 0);
        chk({tag, "_clr_min"}, int'(min_delay), ONES);
        chk({tag, "_clr_max"}, int'(max_delay), 0);
      end
    end

    // retrigger: stim at m=0 and m=2, resp at m=6 (state: stim 0, resp 0)
    step();
    stim = 1'b1;
    first = -1; cnt1 = 0; lat = -1; d0 = -1;
    for (int m = 1; m <= 16; m++) begin
      step();
      if (retrig) begin
        cnt1++;
        if (first < 0) first = m;
      end
      if (delay_valid && lat < 0) begin
        lat = m;
        d0 = int'(delay_cnt);
      end
      if (m == 2) stim = 1'b0;
      if (m == 6) resp = 1'b1;
    end
    chk("retrig_cycle", first, 5);
    chk("retrig_count", cnt1, 1);
    chk("retrig_dv_cycle", lat, 9);
    chk("retrig_delay", d0, 4);
    chk("retrig_min", int'(min_delay), 4);
    chk("retrig_max", int'(max_delay), 4);

    // timeout: stim toggles, resp held (state: stim 0, resp 1)
    step();
    stim = 1'b1;
    first = -1; cnt1 = 0; hits = 0; d1 = -1;
    for (int m = 1; m <= 26; m++) begin
      step();
      if (timeout) begin
        cnt1++;
        if (first < 0) first = m;
      end
      if (m == 10) hits = int'(busy);
      if (m == 23) d1 = int'(busy);
    end
    chk("timeout_cycle", first, 23);
    chk("timeout_count", cnt1, 1);
    chk("timeout_busy_mid", hits, 1);
    chk("timeout_busy_after", d1, 0);
    chk("timeout_delay_kept", int'(delay_cnt), 4);
    resp = 1'b0;
    repeat (5) step();

    // stim and resp coincide mid-measure (state: stim 1, resp 0)
    step();
    stim = 1'b0;
    cnt1 = 0; cnt2 = 0; d0 = -1; d1 = -1;
    for (int m = 1; m <= 14; m++) begin
      step();
      if (retrig) cnt2++;
      if (delay_valid) begin
        cnt1++;
        if (m == 7)  d0 = int'(delay_cnt);
        if (m == 10) d1 = int'(delay_cnt);
      end
      if (m == 4) begin
        stim = 1'b1;
        resp = 1'b1;
      end
      if (m == 7) resp = 1'b0;
    end
    chk("coinc_dv_count", cnt1, 2);
    chk("coinc_first_delay", d0, 4);
    chk("coinc_second_delay", d1, 3);
    chk("coinc_no_retrig", cnt2, 0);
    chk("coinc_perr", int'(polarity_err), 0);
    chk("coinc_min", int'(min_delay), 3);
    chk("coinc_max", int'(max_delay), 4);

    // enable dropped mid-measure (state: stim 1, resp 0)
    step();
    stim = 1'b0;
    hits = 0; d0 = -1; d1 = -1;
    for (int m = 1; m <= 15; m++) begin
      step();
      if (delay_valid || retrig || timeout) hits++;
      if (m == 5) begin
        d0 = int'(busy);
        enable = 1'b0;
      end
      if (m == 6) d1 = int'(busy);
      if (m == 8) enable = 1'b1;
      if (m == 9) resp = 1'b1;
    end
    chk("abort_busy_before", d0, 1);
    chk("abort_busy_after", d1, 0);
    chk("abort_no_pulses", hits, 0);
    chk("abort_busy_end", int'(busy), 0);
    chk("abort_delay_kept", int'(delay_cnt), 3);

    // asynchronous reset while measuring (state: stim 0, resp 1)
    step();
    stim = 1'b1;
    repeat (5) step();
    chk("arst_busy_before", int'(busy), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_busy", int'(busy), 0);
    chk("arst_delay_cnt", int'(delay_cnt), 0);
    chk("arst_min", int'(min_delay), ONES);
    chk("arst_max", int'(max_delay), 0);
    step();
    rst_n = 1'b1;
    repeat (3) step();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/inv_delay_monitor.md
Name: inv_delay_monitor

Overview:
Clocked measurement stage directly downstream of the behavioural inverter model. It samples the inverter's input (stim) and output (resp) asynchronously and measures, in clock cycles, the delay from each stim transition to the following resp transition. It also checks that the output polarity is inverted, detects timeouts and retriggers, and tracks the minimum and maximum delay for the mixed-signal regression.

Parameters:
SYNC_STAGES, 2, synchronizer flops per async input (min 2)
CNT_W, 16, width of delay counter and delay outputs
TIMEOUT, 1000, cycles after a stim edge with no resp edge before timeout (must be < 2^CNT_W - 1)

Ports:
clk  input  1  sampling clock, rising-edge
rst_n  input  1  asynchronous active-low reset
enable  input  1  measurement enable, synchronous to clk
clr_stats  input  1  synchronous clear of min/max/polarity_err
stim  input  1  inverter input, asynchronous
resp  input  1  inverter output, asynchronous
delay_cnt  output  CNT_W  last measured delay in cycles
delay_valid  output  1  one-cycle pulse when delay_cnt updates
timeout  output  1  one-cycle pulse on measurement timeout
retrig  output  1  one-cycle pulse when stim toggles again before resp responds
polarity_err  output  1  sticky; resp settled to the wrong level
min_delay  output  CNT_W  smallest delay since reset/clear
max_delay  output  CNT_W  largest delay since reset/clear
busy  output  1  high while in MEASURE

Behaviour:
- Reset (rst_n low, asynchronous): synchronizers, edge registers and FSM go to 0/IDLE. delay_cnt=0, min_delay=all ones, max_delay=0. All pulses, polarity_err and busy are 0.
- Each of stim and resp passes through SYNC_STAGES flops. The edge detector compares the last sync stage with a previous-value register.
- Edges are suppressed for SYNC_STAGES+1 cycles after reset release (arm counter). During this window the previous-value register tracks the synced value, so the initial level never reads as an edge.
- t0 is the cycle a stim edge is detected. t1 is the cycle a resp edge is detected. The reported delay is t1 - t0 in cycles. Both paths have equal sync latency, so this latency cancels.
- FSM states: IDLE and MEASURE.
- IDLE:
  - enable=1 and stim edge: go to MEASURE, counter=0, expected level = NOT(new synced stim), busy=1 next cycle.
  - Stim edge and resp edge in the same cycle: report delay 0 (delay_valid, polarity check) and stay in IDLE.
  - A resp edge alone in IDLE is ignored.
- MEASURE:
  - The counter increments every cycle.
  - Resp edge at counter value c: delay_cnt = c+1, delay_valid pulses, then go to IDLE.
  - Stim edge with no resp edge: retrig pulses, counter resets, expected level is recomputed, stay in MEASURE.
  - Stim edge and resp edge in the same cycle: report the current measurement first (delay_valid), then restart as above with no retrig pulse.
  - Counter reaches TIMEOUT-1 with no resp edge: timeout pulses, go to IDLE, delay_cnt unchanged.
  - enable=0: abort to IDLE with no pulses.
- Polarity check: at a reported measurement, if the new synced resp value differs from the expected level, set polarity_err. It stays set until clr_stats or reset. The delay is still reported.
- Stats: on delay_valid, min_delay = min(min_delay, delay) and max_delay = max(max_delay, delay), using the new delay in the same cycle.
- clr_stats: restores min/max/polarity_err to reset values the next cycle. It does not affect the FSM. If clr_stats and delay_valid coincide, the clear wins.
- All outputs are registered. Pulse outputs are high for exactly one clk cycle.

Test Plan:
- Basic delay: clk period 10; stim rises 1 after edge 20, resp falls 1 after edge 25 -> delay_valid with delay_cnt=5, polarity_err=0, min=max=5.
- Polarity error: stim rises, resp rises 3 cycles later -> delay_cnt=3, polarity_err=1 sticky; pulse clr_stats -> polarity_err=0, min=all ones, max=0.
- Timeout: TIMEOUT=20, stim toggles, resp held -> timeout pulse exactly 20 cycles after t0, busy drops, delay_cnt keeps its prior value.
- Retrigger and coincidence: stim toggles at t0 and t0+2, resp toggles at t0+6 -> retrig at t0+2, delay_cnt=4. Stim and resp edges in the same cycle while IDLE -> delay_cnt=0.
- Reset and enable: stim=1 held through reset release -> no edge/busy during the arm window. Assert rst_n low mid-MEASURE -> all outputs reset immediately. enable=0 mid-MEASURE -> back to IDLE with no pulses.
- Statistics: delays 7, 3, 9 in sequence -> min_delay=3, max_delay=9.
